// File: rtl/edge_pkg.sv
// Shared types and defaults for the multi-channel edge detector.
// Latency: n/a (types and constants only).
// Backpressure: none; nothing in this file holds state.
// Contents: edge_mode_e per-channel event mode, default parameters, debounce counter width helper.
package edge_pkg;

    // Per-channel event mode: bit 0 arms rising edges, bit 1 arms falling edges.
    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    localparam int DEF_CH          = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DB_CYCLES   = 4;

    // Width of a counter that must reach DB_CYCLES-1 (kept >= 1 bit).
    function automatic int db_cnt_w(input int db_cycles);
        return (db_cycles < 1) ? 1 : $clog2(db_cycles + 1);
    endfunction

endpackage

// File: rtl/edge_channel.sv
// One channel: synchroniser, optional debounce, filtered level, edge pulses, sticky event flag.
// Latency: SYNC_STAGES+1 edges from first sampling edge to level/pulse (SYNC_STAGES+DB_CYCLES with debounce).
// Backpressure: none; pulses are fire-and-forget, evt_status holds until write-1-to-clear.
// Ports: clk, reset_n (async, active-low), in (raw async input), mode (edge_mode_e bits), evt_clear,
//        level, rising_edge, falling_edge, evt_status, evt_status_nxt (combinational next flag for irq).
// Build option: define EDGE_DEBOUNCE_EN to require DB_CYCLES stable cycles before level changes.
module edge_channel
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DB_CYCLES   = DEF_DB_CYCLES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in,
    input  logic [1:0] mode,
    input  logic       evt_clear,
    output logic       level,
    output logic       rising_edge,
    output logic       falling_edge,
    output logic       evt_status,
    output logic       evt_status_nxt
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("edge_channel: SYNC_STAGES must be >= 2");
    end
    if (DB_CYCLES < 1) begin : g_bad_db
        $error("edge_channel: DB_CYCLES must be >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   level_nxt;
    logic                   rise_nxt;
    logic                   fall_nxt;
    logic                   set_evt;
    edge_mode_e             mode_e;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef EDGE_DEBOUNCE_EN
    localparam int                CNT_W    = db_cnt_w(DB_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [CNT_W-1:0] db_cnt;
    logic [CNT_W-1:0] db_cnt_nxt;

    // The counter measures how long sync_out has disagreed with level; any
    // agreement restarts the measurement, so short glitches never flip level.
    always_comb begin
        level_nxt  = level;
        db_cnt_nxt = '0;
        if (sync_out != level) begin
            if (db_cnt == CNT_LAST) begin
                level_nxt = sync_out;
            end else begin
                db_cnt_nxt = db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt_nxt;
        end
    end
`else
    assign level_nxt = sync_out;
`endif

    assign rise_nxt = level_nxt & ~level;
    assign fall_nxt = ~level_nxt & level;

    // Mode only gates the sticky flag; pulses are always produced.
    assign mode_e  = edge_mode_e'(mode);
    assign set_evt = (rise_nxt & (mode_e inside {EDGE_RISE, EDGE_BOTH}))
                   | (fall_nxt & (mode_e inside {EDGE_FALL, EDGE_BOTH}));

    // Set has priority over clear so an event on the clearing edge is kept.
    assign evt_status_nxt = (evt_status & ~evt_clear) | set_evt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level        <= 1'b0;
            rising_edge  <= 1'b0;
            falling_edge <= 1'b0;
            evt_status   <= 1'b0;
        end else begin
            level        <= level_nxt;
            rising_edge  <= rise_nxt;
            falling_edge <= fall_nxt;
            evt_status   <= evt_status_nxt;
        end
    end

endmodule

// File: rtl/edge_detector_array.sv
// Multi-channel synchronised edge detector with sticky per-channel events and a combined irq.
// Latency: SYNC_STAGES+1 edges input-to-pulse (SYNC_STAGES+DB_CYCLES with EDGE_DEBOUNCE_EN); irq on the status edge.
// Backpressure: none; events stay sticky until software writes 1 to evt_clear.
// Ports: clk, reset_n (async, active-low), in[CH], mode[2*CH] (2 bits/channel, edge_mode_e),
//        evt_clear[CH], level[CH], rising_edge[CH], falling_edge[CH], evt_status[CH], irq.
// Build option: define EDGE_DEBOUNCE_EN to enable per-channel debounce of DB_CYCLES cycles.
module edge_detector_array
    import edge_pkg::*;
#(
    parameter int CH          = DEF_CH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DB_CYCLES   = DEF_DB_CYCLES
) (
    input  logic [0:0]      clk,
    input  logic            reset_n,
    input  logic [CH-1:0]   in,
    input  logic [2*CH-1:0] mode,
    input  logic [CH-1:0]   evt_clear,
    output logic [CH-1:0]   level,
    output logic [CH-1:0]   rising_edge,
    output logic [CH-1:0]   falling_edge,
    output logic [CH-1:0]   evt_status,
    output logic            irq
);

    logic [CH-1:0] evt_status_nxt;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        edge_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES)
        ) u_ch (
            .clk            (clk),
            .reset_n        (reset_n),
            .in             (in[i]),
            .mode           (mode[2*i +: 2]),
            .evt_clear      (evt_clear[i]),
            .level          (level[i]),
            .rising_edge    (rising_edge[i]),
            .falling_edge   (falling_edge[i]),
            .evt_status     (evt_status[i]),
            .evt_status_nxt (evt_status_nxt[i])
        );
    end

    // Reduce the next-state flags so irq updates on the same edge as evt_status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |evt_status_nxt;
        end
    end

endmodule
